// File: rtl/multiport_data_memory_pkg.sv
// Shared types and limits for the multi-port data memory.
package multiport_data_memory_pkg;

    localparam int unsigned MEM_PORTS_MAX = 4;

    // One in-flight response: which port it belongs to and how to shape it.
    typedef struct packed {
        logic       valid;
        logic [1:0] port_id;
        logic       err;
        logic       we;
    } mem_resp_tag_t;

endpackage

// File: rtl/multiport_data_memory_if.sv
// OBI-style request/response bundle for N_PORTS requesters.
interface multiport_data_memory_if #(
    parameter int unsigned N_PORTS = 2
);
    logic [N_PORTS-1:0]       req;
    logic [N_PORTS-1:0]       gnt;
    logic [N_PORTS-1:0][31:0] addr;
    logic [N_PORTS-1:0]       we;
    logic [N_PORTS-1:0][3:0]  be;
    logic [N_PORTS-1:0][31:0] wdata;
    logic [N_PORTS-1:0]       rvalid;
    logic [N_PORTS-1:0][31:0] rdata;
    logic [N_PORTS-1:0]       err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/multiport_data_memory_rr_arbiter.sv
// Round-robin arbiter: first requester at or after prio wins; prio moves past the winner.
module multiport_data_memory_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_i,
    input  logic           advance_i,
    output logic [N-1:0]   gnt_o,
    output logic [IdW-1:0] gnt_id_o
);
    logic [IdW-1:0] prio_q;
    logic [IdW-1:0] cand;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdW'((32'(prio_q) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_id_o    = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else if (advance_i) begin
            prio_q <= (32'(gnt_id_o) == N - 1) ? '0 : gnt_id_o + 1'b1;
        end
    end
endmodule

// File: rtl/multiport_data_memory.sv
// N-port data memory: round-robin arbitration onto one single-port RAM with
// in-order tagged responses and address-range error reporting.
module multiport_data_memory
    import multiport_data_memory_pkg::*;
#(
    parameter int unsigned N_PORTS      = 2,
    parameter int unsigned SIZE_IN_KB   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    multiport_data_memory_if.slave  bus
);
    localparam int unsigned Words     = SIZE_IN_KB * 256;
    localparam int unsigned Aw        = $clog2(Words);
    localparam logic [31:0] SizeBytes = 32'(SIZE_IN_KB * 1024);
    localparam int unsigned IdW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0] arb_gnt;
    logic [IdW-1:0]     gnt_id;
    logic               fire;
    logic [31:0]        sel_addr, sel_wdata, offset;
    logic               sel_we, in_range;
    logic [3:0]         sel_be;
    logic [Aw-1:0]      word_idx;

    multiport_data_memory_rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (bus.req),
        .advance_i (fire),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (gnt_id)
    );

    assign bus.gnt   = rst_ni ? arb_gnt : '0;
    assign fire      = rst_ni & (|arb_gnt);
    assign sel_addr  = bus.addr[gnt_id];
    assign sel_we    = bus.we[gnt_id];
    assign sel_be    = bus.be[gnt_id];
    assign sel_wdata = bus.wdata[gnt_id];
    assign offset    = sel_addr - BASE_ADDR;
    assign in_range  = offset < SizeBytes;
    assign word_idx  = offset[Aw+1:2];

    // RAM contents deliberately have no reset so they survive a soft reset.
    logic [31:0] ram_q [Words];
    logic [31:0] ram_rdata_q;

    always_ff @(posedge clk_i) begin
        if (fire && in_range) begin
            if (sel_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_be[b]) ram_q[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata_q <= ram_q[word_idx];
            end
        end
    end

    mem_resp_tag_t tag_d;
    mem_resp_tag_t tag_q [READ_LATENCY];
    mem_resp_tag_t resp;

    always_comb begin
        tag_d         = '0;
        tag_d.valid   = fire;
        tag_d.port_id = 2'(gnt_id);
        tag_d.err     = fire & ~in_range;
        tag_d.we      = fire & sel_we;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign resp = tag_q[READ_LATENCY-1];

    logic [31:0] rdata_out;

    if (READ_LATENCY == 2) begin : g_out_reg
        logic [31:0] rdata_out_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) rdata_out_q <= '0;
            else         rdata_out_q <= ram_rdata_q;
        end
        assign rdata_out = rdata_out_q;
    end else begin : g_no_out_reg
        assign rdata_out = ram_rdata_q;
    end

    logic [N_PORTS-1:0]       rvalid_o_v, err_o_v;
    logic [N_PORTS-1:0][31:0] rdata_o_v;

    // Writes and errors return zero data so stale RAM output never leaks.
    always_comb begin
        rvalid_o_v = '0;
        err_o_v    = '0;
        rdata_o_v  = '0;
        if (resp.valid) begin
            rvalid_o_v[IdW'(resp.port_id)] = 1'b1;
            err_o_v[IdW'(resp.port_id)]    = resp.err;
            if (!resp.err && !resp.we) rdata_o_v[IdW'(resp.port_id)] = rdata_out;
        end
    end

    assign bus.rvalid = rvalid_o_v;
    assign bus.err    = err_o_v;
    assign bus.rdata  = rdata_o_v;
endmodule

// File: tb/tb_multiport_data_memory.sv
// Randomised bench: two DUTs (read latency 1 and 2) share stimulus and one memory model.
module tb_multiport_data_memory;
    localparam int unsigned N      = 3;
    localparam int unsigned KB     = 1;
    localparam int unsigned WORDS  = KB * 256;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] SIZE_B = 32'(KB * 1024);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multiport_data_memory_if #(.N_PORTS(N)) bus_a ();
    multiport_data_memory_if #(.N_PORTS(N)) bus_b ();

    multiport_data_memory #(
        .N_PORTS(N), .SIZE_IN_KB(KB), .BASE_ADDR(BASE), .READ_LATENCY(1)
    ) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    multiport_data_memory #(
        .N_PORTS(N), .SIZE_IN_KB(KB), .BASE_ADDR(BASE), .READ_LATENCY(2)
    ) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    typedef struct {
        int          due;
        int          port;
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          prio = 0;
    bit          pend [N];
    logic [31:0] p_addr [N];
    logic [31:0] p_wdata [N];
    logic        p_we [N];
    logic [3:0]  p_be [N];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_rd [N];
    resp_t       qa [$];
    resp_t       qb [$];
    int          gnt_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus_a.req[i] = pend[i];  bus_b.req[i] = pend[i];
            bus_a.addr[i] = p_addr[i];  bus_b.addr[i] = p_addr[i];
            bus_a.we[i] = p_we[i];  bus_b.we[i] = p_we[i];
            bus_a.be[i] = p_be[i];  bus_b.be[i] = p_be[i];
            bus_a.wdata[i] = p_wdata[i];  bus_b.wdata[i] = p_wdata[i];
        end
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] rv, input logic [N-1:0] er,
                              input logic [N-1:0][31:0] rd, input bit have, input resp_t r);
        logic [N-1:0] erv;
        logic [N-1:0] eer;
        erv = '0;
        eer = '0;
        if (have) begin
            erv[r.port] = 1'b1;
            eer[r.port] = r.err;
        end
        check({tag, "_rvalid"}, 32'(rv), 32'(erv));
        check({tag, "_err"}, 32'(er), 32'(eer));
        for (int p = 0; p < N; p++)
            check($sformatf("%s_rdata%0d", tag, p), rd[p], (have && r.port == p) ? r.rdata : 32'h0);
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance the model.
    task automatic run_cycle();
        int          win, obs, idx;
        logic [N-1:0] eg;
        logic [31:0] off;
        bit          have_a, have_b, inr;
        resp_t       ra, rb, r;
        drive();
        #1;
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && pend[(prio + i) % N]) win = (prio + i) % N;
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        check("gnt_a", 32'(bus_a.gnt), 32'(eg));
        check("gnt_b", 32'(bus_b.gnt), 32'(eg));
        obs = -1;
        for (int i = 0; i < N; i++) if (bus_a.gnt[i]) obs = i;
        gnt_log.push_back(obs);

        ra = '{0, 0, 1'b0, 32'h0};
        rb = ra;
        have_a = (qa.size() > 0) && (qa[0].due == cyc);
        have_b = (qb.size() > 0) && (qb[0].due == cyc);
        if (have_a) ra = qa.pop_front();
        if (have_b) rb = qb.pop_front();
        check_outs("lat1", bus_a.rvalid, bus_a.err, bus_a.rdata, have_a, ra);
        check_outs("lat2", bus_b.rvalid, bus_b.err, bus_b.rdata, have_b, rb);
        for (int i = 0; i < N; i++) if (bus_a.rvalid[i]) last_rd[i] = bus_a.rdata[i];

        if (win >= 0) begin
            off    = p_addr[win] - BASE;
            inr    = off < SIZE_B;
            idx    = int'(off >> 2);
            r.port = win;
            r.err  = !inr;
            r.rdata = (inr && !p_we[win]) ? ref_mem[idx] : 32'h0;
            if (inr && p_we[win]) begin
                for (int b = 0; b < 4; b++)
                    if (p_be[win][b]) ref_mem[idx][8*b +: 8] = p_wdata[win][8*b +: 8];
            end
            r.due = cyc + 1;  qa.push_back(r);
            r.due = cyc + 2;  qb.push_back(r);
            prio = (win + 1) % N;
            pend[win] = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int port, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        pend[port] = 1'b1;  p_we[port] = we;  p_addr[port] = addr;
        p_be[port] = be;    p_wdata[port] = wdata;
    endtask

    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        set_req(port, we, addr, be, wdata);
        for (int k = 0; k < 8 && pend[port]; k++) run_cycle();
        check("grant_wait", 32'(pend[port]), 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle();
    endtask

    task automatic drain();
        bit any;
        for (int k = 0; k < 16; k++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= pend[i];
            if (any) run_cycle();
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) any |= pend[i];
        check("drain_wait", 32'(any), 32'h0);
        idle(3);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        qa.delete();
        qb.delete();
        prio = 0;
        repeat (n) @(negedge clk);
        cyc += n;
        rst_n = 1'b1;
    endtask

    int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;  p_addr[i] = BASE;  p_we[i] = 1'b0;
            p_be[i] = 4'hF;  p_wdata[i] = 32'h0;  last_rd[i] = 32'h0;
        end
        #1 rst_n = 1'b0;

        // Reset with every port requesting.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, BASE + 32'(4 * i), 4'hF, 32'h0);
        drive();
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt_a", 32'(bus_a.gnt), 32'h0);
        check("rst_gnt_b", 32'(bus_b.gnt), 32'h0);
        check("rst_rvalid", 32'(bus_a.rvalid | bus_b.rvalid), 32'h0);
        check("rst_err", 32'(bus_a.err | bus_b.err), 32'h0);
        for (int i = 0; i < N; i++) check("rst_rdata", bus_a.rdata[i] | bus_b.rdata[i], 32'h0);
        @(negedge clk);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rst_n = 1'b1;

        // First cycle after release: only port 1 asks, so it wins at once.
        set_req(1, 1'b1, BASE + 32'h14, 4'hF, 32'h0);
        run_cycle();
        check("first_gnt_port1", 32'(gnt_log[gnt_log.size() - 1]), 32'd1);
        idle(3);

        // Fill the whole RAM back-to-back from port 0.
        for (int w = 0; w < int'(WORDS); w++) issue(0, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom);
        idle(3);

        issue(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        idle(3);
        check("raw_deadbeef", last_rd[0], 32'hDEADBEEF);

        issue(0, 1'b1, BASE + 32'h20, 4'hF, 32'h0);
        issue(0, 1'b1, BASE + 32'h20, 4'b0101, 32'h1122_3344);
        issue(0, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
        idle(3);
        check("be_merge", last_rd[0], 32'h0022_0044);

        // Out of range: aliases word 0 if the range check is broken.
        issue(2, 1'b0, BASE + SIZE_B, 4'hF, 32'h0);
        issue(2, 1'b1, BASE + SIZE_B, 4'hF, 32'hFFFF_FFFF);
        issue(1, 1'b0, BASE - 32'd4, 4'hF, 32'h0);
        issue(1, 1'b0, BASE, 4'hF, 32'h0);
        idle(3);

        // Reset while a read is in flight.
        issue(1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        hold_reset(2);
        idle(4);

        // Full contention straight after reset: strict 0,1,2 rotation.
        gnt_log.delete();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) set_req(i, 1'b0, BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 4'hF, 0);
            run_cycle();
        end
        for (int c = 0; c < 6; c++) check("rotation", 32'(gnt_log[c]), 32'(exp_seq[c]));
        drain();

        last_rd[1] = 32'h0;
        issue(1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        idle(3);
        check("retained_after_reset", last_rd[1], 32'hDEADBEEF);

        // Random mixed traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 9))
                        0:       p_addr[i] = BASE + SIZE_B + 32'($urandom_range(0, 255));
                        1:       p_addr[i] = BASE - 32'($urandom_range(1, 64));
                        default: p_addr[i] = BASE + 32'($urandom_range(0, SIZE_B - 1));
                    endcase
                    set_req(i, 1'($urandom), p_addr[i], 4'($urandom), $urandom);
                end
            end
            run_cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
